// File: rtl/xrv1_pkg.sv
// xrv1_pkg: shared constants and types for the xrv1 ALU sharing logic.
//   XRV_ALU_OP_WIDTH    : width of an ALU opcode
//   XRV_ALU_ARB_MAX_REQ : largest supported number of ALU requesters
//   xrv_alu_op_e        : ALU opcode encoding
package xrv1_pkg;

    localparam int XRV_ALU_OP_WIDTH    = 4;
    localparam int XRV_ALU_ARB_MAX_REQ = 8;

    typedef enum logic [XRV_ALU_OP_WIDTH-1:0] {
        XRV_ALU_ADD  = 4'd0,
        XRV_ALU_SUB  = 4'd1,
        XRV_ALU_SLL  = 4'd2,
        XRV_ALU_SLT  = 4'd3,
        XRV_ALU_SLTU = 4'd4,
        XRV_ALU_XOR  = 4'd5,
        XRV_ALU_SRL  = 4'd6,
        XRV_ALU_SRA  = 4'd7,
        XRV_ALU_OR   = 4'd8,
        XRV_ALU_AND  = 4'd9,
        XRV_ALU_EQ   = 4'd10,
        XRV_ALU_NE   = 4'd11,
        XRV_ALU_LT   = 4'd12,
        XRV_ALU_GE   = 4'd13,
        XRV_ALU_LTU  = 4'd14,
        XRV_ALU_GEU  = 4'd15
    } xrv_alu_op_e;

endpackage

// File: rtl/xrv1_rr_arb.sv
// xrv1_rr_arb: combinational round-robin arbiter.
//   req     : request vector, one bit per requester
//   ptr     : highest-priority requester index for this cycle
//   gnt     : one-hot grant (zero when nothing requests)
//   gnt_idx : encoded index of the granted requester
// The pointer register is owned by the instantiating module.
module xrv1_rr_arb #(
    parameter int N     = 2,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx
);

    int   w_idx;
    logic w_found;

    // Scan N positions starting at ptr, wrapping past N-1 back to 0.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && req[w_idx]) begin
                w_found     = 1'b1;
                gnt[w_idx]  = 1'b1;
                gnt_idx     = PTR_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/xrv1_alu_arb.sv
// xrv1_alu_arb: shares one single-cycle ALU between NUM_REQ_P issue sources.
//   clk_i, rst_i (async, active-high), flush_i (kills in-flight ops)
//   req_*        : per-requester valid/grant and flattened opcode/operands/itag
//   alu_*_o      : registered issue stage driving the ALU; alu_rdy_i back-pressure
//   alu_*_i      : combinational ALU result, captured into the result stage
//   rsp_*        : shared response bus, rsp_vld_o one-hot on the owning requester
// A round-robin grant loads the issue stage; a fire moves the op into the result
// stage; full throughput is one op per cycle with both stages occupied.
module xrv1_alu_arb
    import xrv1_pkg::*;
#(
    parameter int NUM_REQ_P    = 2,
    parameter int DATA_WIDTH_P = 32,
    // 0 means "not set": every instantiation is expected to override this.
    parameter int ITAG_WIDTH_P = 0,
    localparam int ITAG_W      = (ITAG_WIDTH_P > 0) ? ITAG_WIDTH_P : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  flush_i,
    input  logic [NUM_REQ_P-1:0]                  req_vld_i,
    output logic [NUM_REQ_P-1:0]                  req_rdy_o,
    input  logic [NUM_REQ_P*XRV_ALU_OP_WIDTH-1:0] req_opc_i,
    input  logic [NUM_REQ_P*DATA_WIDTH_P-1:0]     req_src0_i,
    input  logic [NUM_REQ_P*DATA_WIDTH_P-1:0]     req_src1_i,
    input  logic [NUM_REQ_P*ITAG_W-1:0]           req_itag_i,
    output logic                                  alu_req_o,
    input  logic                                  alu_rdy_i,
    output logic [XRV_ALU_OP_WIDTH-1:0]           alu_opc_o,
    output logic [DATA_WIDTH_P-1:0]               alu_src0_o,
    output logic [DATA_WIDTH_P-1:0]               alu_src1_o,
    output logic [ITAG_W-1:0]                     alu_itag_o,
    input  logic                                  alu_done_i,
    input  logic [DATA_WIDTH_P-1:0]               alu_res_i,
    input  logic                                  alu_cmp_res_i,
    input  logic [ITAG_W-1:0]                     alu_itag_i,
    output logic [NUM_REQ_P-1:0]                  rsp_vld_o,
    input  logic [NUM_REQ_P-1:0]                  rsp_rdy_i,
    output logic [DATA_WIDTH_P-1:0]               rsp_res_o,
    output logic                                  rsp_cmp_o,
    output logic [ITAG_W-1:0]                     rsp_itag_o
);

    localparam int PTR_W = $clog2(NUM_REQ_P);
    localparam int OPW   = XRV_ALU_OP_WIDTH;

    // Unflattened request payloads
    logic [OPW-1:0]          w_opc  [NUM_REQ_P];
    logic [DATA_WIDTH_P-1:0] w_src0 [NUM_REQ_P];
    logic [DATA_WIDTH_P-1:0] w_src1 [NUM_REQ_P];
    logic [ITAG_W-1:0]       w_itag [NUM_REQ_P];

    // Issue stage
    logic                    r_is_vld;
    logic [PTR_W-1:0]        r_is_owner;
    logic [OPW-1:0]          r_is_opc;
    logic [DATA_WIDTH_P-1:0] r_is_src0;
    logic [DATA_WIDTH_P-1:0] r_is_src1;
    logic [ITAG_W-1:0]       r_is_itag;

    // Result stage
    logic                    r_rs_vld;
    logic [PTR_W-1:0]        r_rs_owner;
    logic [DATA_WIDTH_P-1:0] r_rs_res;
    logic                    r_rs_cmp;
    logic [ITAG_W-1:0]       r_rs_itag;

    logic [PTR_W-1:0]        r_rr_ptr;

    logic                    w_rs_free;
    logic                    w_is_fire;
    logic                    w_is_free;
    logic                    w_grant_en;
    logic                    w_any_gnt;
    logic [NUM_REQ_P-1:0]    w_gnt;
    logic [PTR_W-1:0]        w_gnt_idx;
    logic [PTR_W-1:0]        w_ptr_next;
    // alu_done_i is redundant with the fire condition for a single-cycle ALU.
    logic                    w_unused;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ_P; gi++) begin : g_unpack
            assign w_opc[gi]     = req_opc_i [gi*OPW         +: OPW];
            assign w_src0[gi]    = req_src0_i[gi*DATA_WIDTH_P +: DATA_WIDTH_P];
            assign w_src1[gi]    = req_src1_i[gi*DATA_WIDTH_P +: DATA_WIDTH_P];
            assign w_itag[gi]    = req_itag_i[gi*ITAG_W       +: ITAG_W];
            assign rsp_vld_o[gi] = r_rs_vld && (r_rs_owner == PTR_W'(gi));
        end
    endgenerate

    assign w_unused   = alu_done_i;

    assign w_rs_free  = !r_rs_vld || rsp_rdy_i[r_rs_owner];
    assign w_is_fire  = r_is_vld && alu_rdy_i && w_rs_free;
    assign w_is_free  = !r_is_vld || w_is_fire;
    // rst_i gates the grant so req_rdy_o reads 0 throughout reset.
    assign w_grant_en = w_is_free && !flush_i && !rst_i;

    xrv1_rr_arb #(
        .N     (NUM_REQ_P),
        .PTR_W (PTR_W)
    ) u_rr_arb (
        .req     (req_vld_i),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign req_rdy_o  = w_grant_en ? w_gnt : '0;
    assign w_any_gnt  = |req_rdy_o;
    assign w_ptr_next = (w_gnt_idx == PTR_W'(NUM_REQ_P-1)) ? '0 : w_gnt_idx + PTR_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_is_vld   <= 1'b0;
            r_is_owner <= '0;
            r_is_opc   <= '0;
            r_is_src0  <= '0;
            r_is_src1  <= '0;
            r_is_itag  <= '0;
            r_rs_vld   <= 1'b0;
            r_rs_owner <= '0;
            r_rs_res   <= '0;
            r_rs_cmp   <= 1'b0;
            r_rs_itag  <= '0;
            r_rr_ptr   <= '0;
        end else if (flush_i) begin
            // Only valids drop; payloads and the pointer keep their values.
            r_is_vld <= 1'b0;
            r_rs_vld <= 1'b0;
        end else begin
            if (w_is_fire) begin
                r_rs_vld   <= 1'b1;
                r_rs_owner <= r_is_owner;
                r_rs_res   <= alu_res_i;
                r_rs_cmp   <= alu_cmp_res_i;
                r_rs_itag  <= alu_itag_i;
            end else if (r_rs_vld && rsp_rdy_i[r_rs_owner]) begin
                r_rs_vld <= 1'b0;
            end

            if (w_any_gnt) begin
                r_is_vld   <= 1'b1;
                r_is_owner <= w_gnt_idx;
                r_is_opc   <= w_opc[w_gnt_idx];
                r_is_src0  <= w_src0[w_gnt_idx];
                r_is_src1  <= w_src1[w_gnt_idx];
                r_is_itag  <= w_itag[w_gnt_idx];
                r_rr_ptr   <= w_ptr_next;
            end else if (w_is_fire) begin
                r_is_vld <= 1'b0;
            end
        end
    end

    assign alu_req_o  = r_is_vld;
    assign alu_opc_o  = r_is_opc;
    assign alu_src0_o = r_is_src0;
    assign alu_src1_o = r_is_src1;
    assign alu_itag_o = r_is_itag;
    assign rsp_res_o  = r_rs_res;
    assign rsp_cmp_o  = r_rs_cmp;
    assign rsp_itag_o = r_rs_itag;

endmodule

// File: tb/tb_xrv1_alu_arb.sv
module tb_xrv1_alu_arb;
    import xrv1_pkg::*;

    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int IW  = 4;
    localparam int OPW = XRV_ALU_OP_WIDTH;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic [N-1:0]    req_vld_i = '0;
    logic [N-1:0]    req_rdy_o;
    logic [N*OPW-1:0] req_opc_i;
    logic [N*DW-1:0] req_src0_i;
    logic [N*DW-1:0] req_src1_i;
    logic [N*IW-1:0] req_itag_i;
    logic            alu_req_o;
    logic            alu_rdy_i = 1'b1;
    logic [OPW-1:0]  alu_opc_o;
    logic [DW-1:0]   alu_src0_o;
    logic [DW-1:0]   alu_src1_o;
    logic [IW-1:0]   alu_itag_o;
    logic            alu_done_i;
    logic [DW-1:0]   alu_res_i;
    logic            alu_cmp_res_i;
    logic [IW-1:0]   alu_itag_i;
    logic [N-1:0]    rsp_vld_o;
    logic [N-1:0]    rsp_rdy_i = '1;
    logic [DW-1:0]   rsp_res_o;
    logic            rsp_cmp_o;
    logic [IW-1:0]   rsp_itag_o;

    // Per-requester stimulus and hand-computed expected response
    logic [OPW-1:0] opc_v [N];
    logic [DW-1:0]  a_v   [N];
    logic [DW-1:0]  b_v   [N];
    logic [IW-1:0]  it_v  [N];
    logic [DW-1:0]  er_v  [N];
    logic           ec_v  [N];

    typedef struct packed {
        logic [N-1:0]  own;
        logic [DW-1:0] res;
        logic          cmp;
        logic [IW-1:0] itag;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_p;

    int checks = 0;
    int failures = 0;
    int n_pop = 0;
    int cnt0 = 0;
    int cnt1 = 0;

    always #5 clk = ~clk;

    xrv1_alu_arb #(
        .NUM_REQ_P    (N),
        .DATA_WIDTH_P (DW),
        .ITAG_WIDTH_P (IW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .req_vld_i     (req_vld_i),
        .req_rdy_o     (req_rdy_o),
        .req_opc_i     (req_opc_i),
        .req_src0_i    (req_src0_i),
        .req_src1_i    (req_src1_i),
        .req_itag_i    (req_itag_i),
        .alu_req_o     (alu_req_o),
        .alu_rdy_i     (alu_rdy_i),
        .alu_opc_o     (alu_opc_o),
        .alu_src0_o    (alu_src0_o),
        .alu_src1_o    (alu_src1_o),
        .alu_itag_o    (alu_itag_o),
        .alu_done_i    (alu_done_i),
        .alu_res_i     (alu_res_i),
        .alu_cmp_res_i (alu_cmp_res_i),
        .alu_itag_i    (alu_itag_i),
        .rsp_vld_o     (rsp_vld_o),
        .rsp_rdy_i     (rsp_rdy_i),
        .rsp_res_o     (rsp_res_o),
        .rsp_cmp_o     (rsp_cmp_o),
        .rsp_itag_o    (rsp_itag_o)
    );

    always_comb begin
        req_opc_i  = '0;
        req_src0_i = '0;
        req_src1_i = '0;
        req_itag_i = '0;
        for (int i = 0; i < N; i++) begin
            req_opc_i [i*OPW +: OPW] = opc_v[i];
            req_src0_i[i*DW  +: DW]  = a_v[i];
            req_src1_i[i*DW  +: DW]  = b_v[i];
            req_itag_i[i*IW  +: IW]  = it_v[i];
        end
    end

    // Combinational ALU model (only the ops the bench uses)
    always_comb begin
        alu_res_i     = '0;
        alu_cmp_res_i = 1'b0;
        case (alu_opc_o)
            XRV_ALU_ADD: alu_res_i = alu_src0_o + alu_src1_o;
            XRV_ALU_SUB: alu_res_i = alu_src0_o - alu_src1_o;
            XRV_ALU_LTU: begin
                alu_cmp_res_i = (alu_src0_o < alu_src1_o);
                alu_res_i     = {31'b0, alu_cmp_res_i};
            end
            default: alu_res_i = '0;
        endcase
        alu_done_i = alu_req_o && alu_rdy_i;
        alu_itag_i = alu_itag_o;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [OPW-1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [IW-1:0] it,
                           input logic [DW-1:0] er, input logic ec);
        opc_v[r] = op;
        a_v[r]   = a;
        b_v[r]   = b;
        it_v[r]  = it;
        er_v[r]  = er;
        ec_v[r]  = ec;
        req_vld_i[r] = 1'b1;
    endtask

    // Waits (bounded) for requester r to be granted; cyc = cycles spent waiting.
    task automatic wait_acc(input int r, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_rdy_o[r]) got = 1'b1;
            else cyc++;
            tick();
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL accept_timeout req=%0d actual=no_grant expected=grant", r);
        end
        req_vld_i[r] = 1'b0;
        $display("accept req=%0d waited=%0d itag=%0d", r, cyc, it_v[r]);
    endtask

    // Scoreboard monitor: push on accept, pop/compare on response handshake.
    always @(negedge clk) begin
        if (!rst_i) begin
            if ((rsp_vld_o & rsp_rdy_i) != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual=%b expected=none", rsp_vld_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_pop++;
                    if (rsp_vld_o[0]) cnt0++;
                    if (rsp_vld_o[1]) cnt1++;
                    $display("rsp vld=%b res=%0d cmp=%0b itag=%0d", rsp_vld_o, rsp_res_o, rsp_cmp_o, rsp_itag_o);
                    chk("rsp_owner", 64'(rsp_vld_o), 64'(mon_e.own));
                    chk("rsp_res",   64'(rsp_res_o), 64'(mon_e.res));
                    chk("rsp_cmp",   64'(rsp_cmp_o), 64'(mon_e.cmp));
                    chk("rsp_itag",  64'(rsp_itag_o), 64'(mon_e.itag));
                end
            end
            if (alu_req_o && alu_rdy_i && (rsp_vld_o == '0 || (rsp_vld_o & rsp_rdy_i) != '0))
                chk("alu_done_on_fire", 64'(alu_done_i), 64'd1);
            for (int r = 0; r < N; r++) begin
                if (req_vld_i[r] && req_rdy_o[r]) begin
                    mon_p      = '0;
                    mon_p.own[r] = 1'b1;
                    mon_p.res  = er_v[r];
                    mon_p.cmp  = ec_v[r];
                    mon_p.itag = it_v[r];
                    exp_q.push_back(mon_p);
                end
            end
            if (flush_i) exp_q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int c0;
        int c1;
        for (int i = 0; i < N; i++) begin
            opc_v[i] = '0; a_v[i] = '0; b_v[i] = '0; it_v[i] = '0; er_v[i] = '0; ec_v[i] = 1'b0;
        end

        // Reset state
        repeat (2) tick();
        chk("rst_req_rdy", 64'(req_rdy_o), 64'd0);
        chk("rst_alu_req", 64'(alu_req_o), 64'd0);
        chk("rst_rsp_vld", 64'(rsp_vld_o), 64'd0);
        chk("rst_rsp_res", 64'(rsp_res_o), 64'd0);
        rst_i = 1'b0;

        // Single op: ADD 5+7 itag 3 from requester 0
        set_req(0, XRV_ALU_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0);
        @(negedge clk);
        chk("single_req_rdy", 64'(req_rdy_o), 64'b01);
        tick();
        req_vld_i[0] = 1'b0;
        @(negedge clk);
        chk("single_alu_req_n1", 64'(alu_req_o), 64'd1);
        chk("single_alu_src0", 64'(alu_src0_o), 64'd5);
        chk("single_rsp_vld_n1", 64'(rsp_vld_o), 64'd0);
        tick();
        @(negedge clk);
        chk("single_rsp_vld_n2", 64'(rsp_vld_o), 64'b01);
        chk("single_rsp_res", 64'(rsp_res_o), 64'd12);
        chk("single_rsp_itag", 64'(rsp_itag_o), 64'd3);
        tick();
        repeat (2) tick();

        // Requester 1 alone: ADD 100+23 itag 5 (also returns pointer to 0)
        set_req(1, XRV_ALU_ADD, 32'd100, 32'd23, 4'd5, 32'd123, 1'b0);
        wait_acc(1, cyc);
        chk("req1_single_wait", 64'(cyc), 64'd0);
        repeat (3) tick();

        // Fairness: SUB 10-4 vs LTU 1<2, both valid for 6 cycles
        c0 = cnt0; c1 = cnt1;
        set_req(0, XRV_ALU_SUB, 32'd10, 32'd4, 4'd1, 32'd6, 1'b0);
        set_req(1, XRV_ALU_LTU, 32'd1, 32'd2, 4'd2, 32'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("fair_grant", 64'(req_rdy_o), (i % 2 == 0) ? 64'b01 : 64'b10);
            $display("fair cycle=%0d gnt=%b", i, req_rdy_o);
            tick();
        end
        req_vld_i = '0;
        repeat (4) tick();
        chk("fair_cnt0", 64'(cnt0 - c0), 64'd3);
        chk("fair_cnt1", 64'(cnt1 - c1), 64'd3);

        // Back-pressure on requester 0 with a third op pending
        rsp_rdy_i = 2'b10;
        set_req(0, XRV_ALU_ADD, 32'd1, 32'd1, 4'd6, 32'd2, 1'b0);
        wait_acc(0, cyc);
        set_req(0, XRV_ALU_ADD, 32'd2, 32'd2, 4'd7, 32'd4, 1'b0);
        wait_acc(0, cyc);
        chk("bp_second_wait", 64'(cyc), 64'd0);
        set_req(0, XRV_ALU_ADD, 32'd3, 32'd3, 4'd8, 32'd6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_req_rdy", 64'(req_rdy_o), 64'd0);
            chk("bp_rsp_vld", 64'(rsp_vld_o), 64'b01);
            chk("bp_rs_res", 64'(rsp_res_o), 64'd2);
            chk("bp_rs_itag", 64'(rsp_itag_o), 64'd6);
            chk("bp_is_src0", 64'(alu_src0_o), 64'd2);
            chk("bp_is_itag", 64'(alu_itag_o), 64'd7);
            tick();
        end
        rsp_rdy_i = 2'b11;
        wait_acc(0, cyc);
        repeat (4) tick();

        // ALU stall: IS holds SUB 50-8 itag 9, no new grant
        alu_rdy_i = 1'b0;
        set_req(1, XRV_ALU_SUB, 32'd50, 32'd8, 4'd9, 32'd42, 1'b0);
        wait_acc(1, cyc);
        chk("stall_first_wait", 64'(cyc), 64'd0);
        set_req(0, XRV_ALU_ADD, 32'd7, 32'd8, 4'd10, 32'd15, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_alu_req", 64'(alu_req_o), 64'd1);
            chk("stall_opc", 64'(alu_opc_o), 64'(XRV_ALU_SUB));
            chk("stall_src0", 64'(alu_src0_o), 64'd50);
            chk("stall_src1", 64'(alu_src1_o), 64'd8);
            chk("stall_itag", 64'(alu_itag_o), 64'd9);
            chk("stall_req_rdy", 64'(req_rdy_o), 64'd0);
            tick();
        end
        alu_rdy_i = 1'b1;
        wait_acc(0, cyc);
        repeat (4) tick();

        // Flush with both stages full and both requesters valid
        set_req(0, XRV_ALU_ADD, 32'd30, 32'd1, 4'd4, 32'd31, 1'b0);
        wait_acc(0, cyc);
        set_req(1, XRV_ALU_ADD, 32'd40, 32'd2, 4'd11, 32'd42, 1'b0);
        wait_acc(1, cyc);
        flush_i = 1'b1;
        set_req(0, XRV_ALU_ADD, 32'd20, 32'd22, 4'd12, 32'd42, 1'b0);
        set_req(1, XRV_ALU_LTU, 32'd5, 32'd3, 4'd13, 32'd0, 1'b0);
        @(negedge clk);
        chk("flush_full_is", 64'(alu_req_o), 64'd1);
        chk("flush_full_rs", 64'(rsp_vld_o), 64'b01);
        chk("flush_no_grant", 64'(req_rdy_o), 64'd0);
        tick();
        flush_i = 1'b0;
        chk("flush_alu_req", 64'(alu_req_o), 64'd0);
        chk("flush_rsp_vld", 64'(rsp_vld_o), 64'd0);
        wait_acc(0, cyc);
        chk("flush_next_gnt0", 64'(cyc), 64'd0);
        wait_acc(1, cyc);
        repeat (4) tick();

        // Async reset between edges with both stages full
        set_req(0, XRV_ALU_ADD, 32'd9, 32'd9, 4'd14, 32'd18, 1'b0);
        wait_acc(0, cyc);
        set_req(1, XRV_ALU_ADD, 32'd1, 32'd2, 4'd15, 32'd3, 1'b0);
        wait_acc(1, cyc);
        set_req(0, XRV_ALU_ADD, 32'd4, 32'd4, 4'd1, 32'd8, 1'b0);
        #2;
        rst_i = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_req_rdy", 64'(req_rdy_o), 64'd0);
        chk("arst_alu", {31'b0, alu_req_o, alu_opc_o, alu_itag_o, 24'b0}, 64'd0);
        chk("arst_alu_src", {alu_src0_o, alu_src1_o}, 64'd0);
        chk("arst_rsp_vld", 64'(rsp_vld_o), 64'd0);
        chk("arst_rsp", {27'b0, rsp_res_o, rsp_cmp_o, rsp_itag_o}, 64'd0);
        tick();
        tick();
        rst_i = 1'b0;
        wait_acc(0, cyc);
        chk("arst_first_grant", 64'(cyc), 64'd0);
        repeat (4) tick();

        chk("final_q_empty", 64'(exp_q.size()), 64'd0);
        chk("resp_total", 64'(n_pop), 64'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
